// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial ALU, one bit per cycle LSB first, with valid/ready handshake.
// Revision 1.0
`default_nettype none

module alu_serial_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [IW-1:0]    idx;
  logic             carry;

  logic             accept, last, sub_op;
  logic             ai, bi, bm, sum, carry_nxt, bit_res;
  logic [WIDTH-1:0] res_nxt;

  assign accept = in_valid && (state == S_IDLE);
  assign last   = (idx == IW'(WIDTH - 1));
  assign sub_op = (op_q == 3'b110) || (op_q == 3'b111);

  // Single full-adder slice shared across all bit positions.
  assign ai        = a_q[idx];
  assign bi        = b_q[idx];
  assign bm        = sub_op ? ~bi : bi;
  assign sum       = ai ^ bm ^ carry;
  assign carry_nxt = (ai & bm) | ((ai ^ bm) & carry);

  always_comb begin
    bit_res = 1'b0;
    case (op_q)
      3'b000:                 bit_res = ai & bi;
      3'b001:                 bit_res = ai | bi;
      3'b011:                 bit_res = ~(ai & bi);
      3'b100:                 bit_res = ~(ai | bi);
      3'b010, 3'b110, 3'b101: bit_res = sum;
      default:                bit_res = 1'b0;
    endcase
  end

  always_comb begin
    res_nxt      = result;
    res_nxt[idx] = bit_res;
    if (last && (op_q == 3'b111)) begin
      res_nxt = {{(WIDTH-1){1'b0}}, sum};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      op_q  <= op;
      idx   <= '0;
      carry <= (op == 3'b110) || (op == 3'b111);
    end else if (state == S_RUN) begin
      result <= res_nxt;
      carry  <= carry_nxt;
      if (last) begin
        // Flags are computed from the final bit so they appear together with out_valid.
        idx       <= '0;
        zero      <= (res_nxt == '0);
        carry_out <= (op_q == 3'b010 || op_q == 3'b110 || op_q == 3'b101) ? carry_nxt : 1'b0;
        overflow  <= (op_q == 3'b010 || op_q == 3'b110) ? (carry ^ carry_nxt) : 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
// tb_alu_serial_ctrl: directed and random checks of alu_serial_ctrl against an arithmetic model.
// Revision 1.0
`default_nettype none

module tb_alu_serial_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero, carry_out, overflow, busy;

  int n_assert = 0;
  int n_fail   = 0;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .carry_out(carry_out), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {zero, overflow, carry_out, result}.
  function automatic logic [W+2:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    c = 1'b0;
    v = 1'b0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b011: r = ~(x & y);
      3'b100: r = ~(x | y);
      3'b010, 3'b101: begin
        s = {1'b0, x} + {1'b0, y};
        r = s[W-1:0];
        c = s[W];
        if (o == 3'b010) v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      3'b110: begin
        s = {1'b0, x} + {1'b0, ~y} + 1;
        r = s[W-1:0];
        c = s[W];
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
      default: begin
        s = {1'b0, x} - {1'b0, y};
        r = '0;
        r[0] = s[W-1];
      end
    endcase
    return {(r == '0), v, c, r};
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    logic [W+2:0] e;
    int n;
    e = model(o, x, y);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    // Scramble inputs while running; they must be ignored.
    in_valid = 1'b1; op = 3'($urandom); a = $urandom; b = $urandom;
    check("busy_run", busy, 1);
    check("in_ready_run", in_ready, 0);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      a = $urandom; b = $urandom;
    end
    check("latency", n, W + 1);
    check("result", result, e[W-1:0]);
    check("carry_out", carry_out, e[W]);
    check("overflow", overflow, e[W+1]);
    check("zero", zero, e[W+2]);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_result", {result, zero, carry_out, overflow}, {e[W-1:0], e[W+2], e[W], e[W+1]});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {result, zero, carry_out, overflow}, '0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    do_op(3'b010, 32'h7FFFFFFF, 32'h00000001, 0);
    do_op(3'b110, 32'd5, 32'd5, 0);
    do_op(3'b110, 32'h80000000, 32'd1, 0);
    do_op(3'b111, 32'hFFFFFFFD, 32'd2, 0);
    do_op(3'b111, 32'd2, 32'hFFFFFFFD, 0);
    do_op(3'b100, 32'd0, 32'd0, 0);
    do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    do_op(3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
    do_op(3'b001, 32'hF0F0F0F0, 32'h0FF00FF0, 5);
    do_op(3'b101, 32'hFFFFFFFF, 32'd1, 0);

    // Reset mid-run: outputs return to reset values without waiting for an edge.
    @(negedge clk);
    in_valid = 1'b1; op = 3'b010; a = 32'h12345678; b = 32'h1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_flags", {result, zero, carry_out, overflow}, '0);
    @(negedge clk);
    rst = 1'b0;
    do_op(3'b010, 32'd3, 32'd4, 0);

    for (int t = 0; t < 20; t++) begin
      do_op(3'($urandom), $urandom, (t % 4 == 0) ? a : 32'($urandom), t % 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
